// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and parameter defaults for the set/reset command generator.
package sr_cmd_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned PULSE_DEFAULT    = 1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP
  } state_e;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and latch command outputs of the command generator.
interface sr_cmd_gen_if;
  logic btn_set;
  logic btn_rst;
  logic s;
  logic r;
  logic conflict;
  logic busy;

  modport master (
    output btn_set, btn_rst,
    input  s, r, conflict, busy
  );

  modport slave (
    input  btn_set, btn_rst,
    output s, r, conflict, busy
  );
endinterface

// File: rtl/sr_cmd_gen_debounce.sv
// Synchroniser plus counting debouncer; emits a one-cycle request on each
// accepted 0->1 change of the stable level.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic req_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic       req_q, req_d;
  logic [7:0] cnt_q, cnt_d;

  // The request is registered together with the level change so the FSM
  // sees it in the very cycle the new stable level becomes visible.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    req_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q + 8'd1 == CNT_LAST) begin
        stable_d = ~stable_q;
        req_d    = ~stable_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncing pushbuttons into non-overlapping, fixed-width set/reset
// pulses for a downstream SR latch, with reset winning any conflict.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned PULSE_WIDTH     = PULSE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sr_cmd_gen_if.slave    bus
);

  localparam logic [3:0] PCNT_LAST = 4'(PULSE_WIDTH - 1);

  logic       set_req, rst_req;
  logic       set_any, rst_any;
  state_e     state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       pend_s_q, pend_s_d, pend_r_q, pend_r_d;
  logic       s_q, s_d, r_q, r_d, conflict_q, conflict_d, busy_q, busy_d;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .btn_i (bus.btn_set),
    .req_o (set_req)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk   (clk),
    .rst   (rst),
    .btn_i (bus.btn_rst),
    .req_o (rst_req)
  );

  assign set_any = set_req | pend_s_q;
  assign rst_any = rst_req | pend_r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      busy_q     <= busy_d;
    end
  end

  // Dispatch only from IDLE; anything arriving while busy is parked in the
  // one-deep pending flags. Reset always wins and discards a waiting set.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    unique case (state_q)
      IDLE: begin
        if (rst_any) begin
          state_d  = PULSE_R;
          pcnt_d   = '0;
          pend_r_d = 1'b0;
          pend_s_d = 1'b0;
        end else if (set_any) begin
          state_d  = PULSE_S;
          pcnt_d   = '0;
          pend_s_d = 1'b0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (set_req) pend_s_d = 1'b1;
        if (rst_req) pend_r_d = 1'b1;
        if (pcnt_q == PCNT_LAST) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      GAP: begin
        if (set_req) pend_s_d = 1'b1;
        if (rst_req) pend_r_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    s_d        = (state_d == PULSE_S);
    r_d        = (state_d == PULSE_R);
    busy_d     = (state_d != IDLE);
    conflict_d = (state_q == IDLE) && rst_any && set_any;
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random-bounce checks of sr_cmd_gen with DEBOUNCE_CYCLES=4, PULSE_WIDTH=2.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   s_run = 0, r_run = 0, s_pulses = 0, r_pulses = 0;

  sr_cmd_gen_if bus();

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic es, input logic er,
                        input logic ec, input logic eb);
    check({tag, "_s"}, bus.s, es);
    check({tag, "_r"}, bus.r, er);
    check({tag, "_conflict"}, bus.conflict, ec);
    check({tag, "_busy"}, bus.busy, eb);
  endtask

  // Exclusivity every cycle and pulse width at every falling edge of s/r.
  task automatic track();
    check("rnd_excl", bus.s & bus.r, 1'b0);
    if (bus.s) s_run++;
    else if (s_run != 0) begin
      check_int("rnd_s_width", s_run, 2);
      s_pulses++;
      s_run = 0;
    end
    if (bus.r) r_run++;
    else if (r_run != 0) begin
      check_int("rnd_r_width", r_run, 2);
      r_pulses++;
      r_run = 0;
    end
  endtask

  initial begin
    int hold_s, hold_r;
    bus.btn_set = 1'b0;
    bus.btn_rst = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean set press: s at edges 7,8, GAP at 9, idle at 10
    bus.btn_set = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 12)
        check4($sformatf("set_k%0d", k), (k == 7 || k == 8), 1'b0, 1'b0,
               (k >= 7 && k <= 9));
    end
    bus.btn_set = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check4($sformatf("set_rel_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Bouncing reset button never settles high long enough
    for (int k = 1; k <= 10; k++) begin
      bus.btn_rst = ~bus.btn_rst;
      tick();
      check4($sformatf("bounce_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.btn_rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check4($sformatf("bounce_settle_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Simultaneous set and reset: reset served, conflict flagged once
    bus.btn_set = 1'b1;
    bus.btn_rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check4($sformatf("both_k%0d", k), 1'b0, (k == 7 || k == 8), (k == 7),
             (k >= 7 && k <= 9));
    end
    bus.btn_set = 1'b0;
    bus.btn_rst = 1'b0;
    repeat (10) tick();

    // Reset request lands during PULSE_S: s 7,8; GAP 9; IDLE 10; r 11,12
    bus.btn_set = 1'b1;
    tick();
    bus.btn_rst = 1'b1;
    check4("queue_k1", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check4($sformatf("queue_k%0d", k), (k == 7 || k == 8), (k == 11 || k == 12),
             1'b0, ((k >= 7 && k <= 9) || (k >= 11 && k <= 13)));
    end
    bus.btn_set = 1'b0;
    bus.btn_rst = 1'b0;
    repeat (10) tick();

    // Reset asserted mid PULSE_R
    bus.btn_rst = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    check4("midpulse_pre", 1'b0, 1'b1, 1'b0, 1'b1);
    bus.btn_rst = 1'b0;
    rst = 1'b1;
    tick();
    check4("midpulse_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check4($sformatf("midpulse_after_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Button held high through reset release yields exactly one pulse
    bus.btn_set = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check4($sformatf("held_k%0d", k), (k == 7 || k == 8), 1'b0, 1'b0,
             (k >= 7 && k <= 9));
    end
    bus.btn_set = 1'b0;
    repeat (10) tick();

    // Random bouncing on both buttons
    hold_s = 0;
    hold_r = 0;
    for (int i = 0; i < 10000; i++) begin
      if (hold_s == 0) begin
        bus.btn_set = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 12);
      end
      if (hold_r == 0) begin
        bus.btn_rst = 1'($urandom_range(0, 1));
        hold_r = $urandom_range(1, 12);
      end
      hold_s--;
      hold_r--;
      tick();
      track();
    end
    bus.btn_set = 1'b0;
    bus.btn_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      track();
    end
    check("rnd_s_seen", s_pulses > 0, 1'b1);
    check("rnd_r_seen", r_pulses > 0, 1'b1);
    check4("rnd_final", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
